tx_path_top: RTL and testbench

- Baseband transmit path for the simple SDR.
- Consumes a serial 1-bit AXI-style stream and maps bit pairs to QPSK symbols.
- Upsamples each symbol by 4 through a fixed 8-tap polyphase pulse-shaping FIR.
- Emits a 24-bit {I,Q} sample stream (12-bit two's complement each) toward the async output FIFO / DAC clock domain.

---
 rtl/tx_path_top.sv | 150 +++++++++++++++
 tb/tb_tx_path_top.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_path_top.sv
`default_nettype none
// ============================================================================
//  Module   : tx_path_top
//  Function : Baseband QPSK transmit path. Pairs serial bits into (I,Q)
//             symbols, upsamples by 4 through an 8-tap polyphase pulse
//             shaper and emits a 2xDATA_W {I,Q} sample stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_path_top #(
   parameter int AMP_STEP = 256,
   parameter int DATA_W   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [2*DATA_W-1:0]   out_data,
   input  logic                  out_ready
);

   // Amplitude scale in the arithmetic width of one output rail.
   localparam logic signed [DATA_W-1:0] C_AMP = DATA_W'(AMP_STEP);

   // Pulse-shaping taps. Phase p of the current symbol uses C_TAPS[p];
   // the tail of the previous symbol overlaps with C_TAPS[p+4].
   localparam logic [2:0] C_TAPS [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                                         3'd4, 3'd3, 3'd2, 3'd1};

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic              bit_cnt_q,  bit_cnt_d;   // 1 = first bit of pair held
   logic              bit_q,      bit_d;       // held I bit
   logic              sym_busy_q, sym_busy_d;  // symbol being emitted
   logic [1:0]        phase_q,    phase_d;     // upsampling phase 0..3
   logic              ci_neg_q,   ci_neg_d;    // current I is -1 when set
   logic              cq_neg_q,   cq_neg_d;    // current Q is -1 when set
   logic signed [1:0] pi_q,       pi_d;        // previous I in {-1,0,+1}
   logic signed [1:0] pq_q,       pq_d;        // previous Q in {-1,0,+1}

   logic              in_fire;
   logic              out_fire;
   logic signed [DATA_W-1:0] samp_i;
   logic signed [DATA_W-1:0] samp_q;

   // Sign-extend a symbol value in {-1,0,+1} to the rail width.
   function automatic logic signed [DATA_W-1:0] f_ext(input logic signed [1:0] v);
      return {{(DATA_W-2){v[1]}}, v};
   endfunction

   // One shaped rail sample: (cur*h[ph] + prev*h[ph+4]) * AMP_STEP.
   function automatic logic signed [DATA_W-1:0] f_shape(
      input logic              cur_neg,
      input logic signed [1:0] prev,
      input logic [1:0]        ph
   );
      logic signed [DATA_W-1:0] cur_v;
      logic signed [DATA_W-1:0] prv_v;
      logic signed [DATA_W-1:0] h_cur;
      logic signed [DATA_W-1:0] h_prv;
      logic signed [DATA_W-1:0] acc;
      cur_v = f_ext(cur_neg ? 2'sb11 : 2'sb01);
      prv_v = f_ext(prev);
      h_cur = DATA_W'(C_TAPS[{1'b0, ph}]);
      h_prv = DATA_W'(C_TAPS[{1'b1, ph}]);
      acc   = cur_v * h_cur + prv_v * h_prv;
      return acc * C_AMP;
   endfunction

   // Handshakes. The first bit of a pair is always welcome; the second only
   // once the symbol register has drained. Both terms are registered.
   always_comb begin
      in_ready  = (bit_cnt_q == 1'b0) || !sym_busy_q;
      out_valid = sym_busy_q;
      in_fire   = in_valid && in_ready;
      out_fire  = sym_busy_q && out_ready;
   end

   // Output samples built purely from registered state; zero while idle.
   always_comb begin
      samp_i   = f_shape(ci_neg_q, pi_q, phase_q);
      samp_q   = f_shape(cq_neg_q, pq_q, phase_q);
      out_data = sym_busy_q ? {samp_i, samp_q} : '0;
   end

   // Next-state: bit collection, symbol load and phase advance.
   // A second-bit load needs !sym_busy while a phase advance needs sym_busy,
   // so the two branches never act in the same cycle.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      bit_d      = bit_q;
      sym_busy_d = sym_busy_q;
      phase_d    = phase_q;
      ci_neg_d   = ci_neg_q;
      cq_neg_d   = cq_neg_q;
      pi_d       = pi_q;
      pq_d       = pq_q;

      if (out_fire) begin
         if (phase_q == 2'd3) begin
            pi_d       = ci_neg_q ? 2'sb11 : 2'sb01;
            pq_d       = cq_neg_q ? 2'sb11 : 2'sb01;
            sym_busy_d = 1'b0;
            phase_d    = 2'd0;
         end else begin
            phase_d = phase_q + 2'd1;
         end
      end

      if (in_fire) begin
         if (bit_cnt_q == 1'b0) begin
            bit_d     = in_data;
            bit_cnt_d = 1'b1;
         end else begin
            ci_neg_d   = bit_q;
            cq_neg_d   = in_data;
            sym_busy_d = 1'b1;
            phase_d    = 2'd0;
            bit_cnt_d  = 1'b0;
         end
      end
   end

   // State register; reset clears everything, including a symbol in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q  <= 1'b0;
         bit_q      <= 1'b0;
         sym_busy_q <= 1'b0;
         phase_q    <= 2'd0;
         ci_neg_q   <= 1'b0;
         cq_neg_q   <= 1'b0;
         pi_q       <= 2'sb00;
         pq_q       <= 2'sb00;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         bit_q      <= bit_d;
         sym_busy_q <= sym_busy_d;
         phase_q    <= phase_d;
         ci_neg_q   <= ci_neg_d;
         cq_neg_q   <= cq_neg_d;
         pi_q       <= pi_d;
         pq_q       <= pq_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tx_path_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_path_top
//  Function : Self-checking bench for tx_path_top: cycle vector table,
//             directed corner sequences and a backpressured random stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_path_top;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_data = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [23:0] out_data;
   logic        out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   tx_path_top #(.AMP_STEP(256), .DATA_W(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        d;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [23:0] e_data;
   } vec_t;

   vec_t vecs [28];

   function automatic vec_t mkv(input logic iv, input logic d, input logic ordy,
                                input logic e_ir, input logic e_ov,
                                input logic [23:0] e_data);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk1 ("rst_out_valid", out_valid, 1'b0);
      chk1 ("rst_in_ready",  in_ready,  1'b1);
      chk24("rst_out_data",  out_data,  24'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bit done = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = b;
         #1;
         if (in_ready) begin
            done = 1'b1;
            @(posedge clk);
         end
      end
      #1 in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_bit_timeout: in_ready never high");
      end
   endtask

   task automatic expect_sample(input string name, input logic [23:0] exp);
      bit done = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         #1;
         if (out_valid) begin
            done = 1'b1;
            chk24(name, out_data, exp);
            @(posedge clk);
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_timeout: out_valid never high", name);
      end
   endtask

   // Random-stream golden model storage
   logic        rbits [800];
   logic [23:0] rexp  [1600];

   function automatic logic [11:0] rail(input int cur, input int prv, input int ph);
      int h [8];
      int v;
      h = '{1, 2, 3, 4, 4, 3, 2, 1};
      v = (cur * h[ph] + prv * h[ph + 4]) * 256;
      return 12'(v);
   endfunction

   initial begin
      // ---- vector table (applied from reset, one entry per cycle) ----
      vecs[0]  = mkv(1, 0, 1, 1, 0, 24'h000000);
      vecs[1]  = mkv(1, 0, 1, 1, 0, 24'h000000);
      vecs[2]  = mkv(0, 0, 1, 1, 1, 24'h100100);
      vecs[3]  = mkv(0, 0, 1, 1, 1, 24'h200200);
      vecs[4]  = mkv(0, 0, 1, 1, 1, 24'h300300);
      vecs[5]  = mkv(0, 0, 1, 1, 1, 24'h400400);
      vecs[6]  = mkv(1, 0, 1, 1, 0, 24'h000000);
      vecs[7]  = mkv(1, 0, 1, 1, 0, 24'h000000);
      vecs[8]  = mkv(0, 0, 1, 1, 1, 24'h500500);
      vecs[9]  = mkv(0, 0, 1, 1, 1, 24'h500500);
      vecs[10] = mkv(0, 0, 1, 1, 1, 24'h500500);
      vecs[11] = mkv(0, 0, 1, 1, 1, 24'h500500);
      vecs[12] = mkv(1, 1, 1, 1, 0, 24'h000000);
      vecs[13] = mkv(1, 1, 1, 1, 0, 24'h000000);
      vecs[14] = mkv(0, 0, 1, 1, 1, 24'h300300);
      vecs[15] = mkv(0, 0, 1, 1, 1, 24'h100100);
      vecs[16] = mkv(0, 0, 1, 1, 1, 24'hF00F00);
      vecs[17] = mkv(0, 0, 1, 1, 1, 24'hD00D00);
      vecs[18] = mkv(1, 0, 1, 1, 0, 24'h000000);
      vecs[19] = mkv(1, 1, 1, 1, 0, 24'h000000);
      vecs[20] = mkv(1, 0, 0, 1, 1, 24'hD00B00);
      vecs[21] = mkv(1, 1, 0, 0, 1, 24'hD00B00);
      vecs[22] = mkv(1, 1, 1, 0, 1, 24'hD00B00);
      vecs[23] = mkv(1, 1, 1, 0, 1, 24'hF00B00);
      vecs[24] = mkv(1, 1, 1, 0, 1, 24'h100B00);
      vecs[25] = mkv(1, 1, 1, 0, 1, 24'h300B00);
      vecs[26] = mkv(1, 1, 1, 1, 0, 24'h000000);
      vecs[27] = mkv(0, 0, 1, 1, 1, 24'h500B00);

      do_reset();
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
         #1;
         chk1 ($sformatf("vec%0d_in_ready", i),  in_ready,  vecs[i].e_ir);
         chk1 ($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
         chk24($sformatf("vec%0d_out_data", i),  out_data,  vecs[i].e_data);
      end
      @(negedge clk);
      in_valid = 1'b0;

      // ---- bits 0,1 from reset ----
      do_reset();
      send_bit(1'b0);
      send_bit(1'b1);
      expect_sample("iq01_ph0", 24'h100F00);
      expect_sample("iq01_ph1", 24'h200E00);
      expect_sample("iq01_ph2", 24'h300D00);
      expect_sample("iq01_ph3", 24'h400C00);

      // ---- asynchronous reset at phase 2 ----
      do_reset();
      send_bit(1'b0);
      send_bit(1'b0);
      expect_sample("mid_ph0", 24'h100100);
      expect_sample("mid_ph1", 24'h200200);
      @(negedge clk);
      #1;
      chk1 ("mid_ph2_valid", out_valid, 1'b1);
      chk24("mid_ph2_data",  out_data,  24'h300300);
      rst = 1'b1;
      #1;
      chk1 ("mid_rst_out_valid", out_valid, 1'b0);
      chk1 ("mid_rst_in_ready",  in_ready,  1'b1);
      chk24("mid_rst_out_data",  out_data,  24'h0);
      @(negedge clk);
      rst = 1'b0;
      send_bit(1'b0);
      send_bit(1'b0);
      expect_sample("post_rst_ph0", 24'h100100);
      expect_sample("post_rst_ph1", 24'h200200);
      expect_sample("post_rst_ph2", 24'h300300);
      expect_sample("post_rst_ph3", 24'h400400);

      // ---- random stream with random backpressure ----
      begin
         int pi, pq, ci, cq;
         pi = 0; pq = 0;
         for (int i = 0; i < 800; i++) rbits[i] = 1'($urandom_range(0, 1));
         for (int s = 0; s < 400; s++) begin
            ci = rbits[2*s]   ? -1 : 1;
            cq = rbits[2*s+1] ? -1 : 1;
            for (int ph = 0; ph < 4; ph++)
               rexp[4*s+ph] = {rail(ci, pi, ph), rail(cq, pq, ph)};
            pi = ci; pq = cq;
         end
      end
      do_reset();
      begin
         int          idx = 0;
         int          k = 0;
         int          cyc = 0;
         bit          prev_stall = 1'b0;
         logic [23:0] prev_data = '0;
         while (k < 1600 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (idx < 800) && ($urandom_range(0, 3) != 0);
            in_data   = (idx < 800) ? rbits[idx] : 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
               chk1 ("rnd_stall_valid", out_valid, 1'b1);
               chk24("rnd_stall_data",  out_data,  prev_data);
            end
            chk1("rnd_in_ready", in_ready, !((idx % 2 == 1) && out_valid));
            if (out_valid && out_ready) begin
               chk24($sformatf("rnd_sample%0d", k), out_data, rexp[k]);
               k++;
            end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
         end
         in_valid = 1'b0;
         checks++;
         if (k != 1600) begin
            errors++;
            $display("FAIL rnd_sample_count: got %0d expected 1600", k);
         end
         out_ready = 1'b1;
         repeat (6) begin
            @(negedge clk);
            #1;
            chk1("rnd_no_extra", out_valid, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
